led_status_ctrl: RTL and testbench
==================================

Name: led_status_ctrl

Overview:
- Parametrised successor to the single-bank RGB status LED driver.
- Drives N_LEDS RGB LEDs, one per monitored unit. Each LED has its own fault-progress state machine, driven by that unit's fault flag and by the shared bot events.
- Adds global overlays on top of the per-LED colours:
  - a sticky run-complete green blink;
  - a retriggerable node-crossing white flash.
- Sits between the unit controllers and the LED pins. All outputs are registered, with a 1-cycle latency.

Parameters:
- N_LEDS, 3, number of RGB LEDs / monitored units.
- BLINK_HALF, 3125000, clock cycles per blink half-period (1 s at 3.125 MHz).
- FLASH_CYCLES, 312500, length of the node white flash in cycles (100 ms).

Ports:
- clk_3125KHz  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- unit_fault  in  N_LEDS  level; bit i high means unit i currently owns a fault and accepts events.
- fault_detect  in  1  single-cycle pulse: fault located.
- block_picked  in  1  single-cycle pulse: replacement block picked.
- object_drop  in  1  single-cycle pulse: block dropped, fault repaired.
- node_flag  in  1  single-cycle pulse: node crossed.
- run_complete  in  1  single-cycle pulse: run finished.
- led_r  out  N_LEDS  red drive, bit i is LED i.
- led_g  out  N_LEDS  green drive.
- led_b  out  N_LEDS  blue drive.

Behaviour:
- Reset:
  - rst is sampled on the clk_3125KHz edge.
  - It forces all channel FSMs to IDLE, blink_phase=0, blink counter=0, flash counter=0, run_done=0, and led_r/led_g/led_b=0.
  - Reset mid-blink or mid-flash aborts immediately; outputs are 0 on the next cycle.
- Per-channel FSM, channel i:
  - Events affect channel i only in cycles where unit_fault[i]=1. Otherwise the state holds.
  - IDLE (off) -> ARMED when unit_fault[i]=1.
  - ARMED (red solid) -> DETECTED on fault_detect.
  - DETECTED (blue solid) -> PICKED on block_picked.
  - PICKED: blue, blinking with blink_phase.
  - ARMED, DETECTED or PICKED -> DONE on object_drop.
  - DONE (green solid) is terminal until rst.
  - Simultaneous events in one cycle: object_drop > block_picked > fault_detect. Only one transition occurs per cycle.
  - Dropping unit_fault[i] freezes the state; it does not return to IDLE.
  - In IDLE with unit_fault[i]=1, a same-cycle event is ignored; that cycle only moves IDLE -> ARMED.
- Blink timer:
  - Free-running counter 0..BLINK_HALF-1.
  - On reaching BLINK_HALF-1 it wraps to 0 and toggles blink_phase.
  - Counter width is clog2(BLINK_HALF).
- Node flash:
  - node_flag loads the flash counter with FLASH_CYCLES. The counter decrements to 0.
  - A retrigger while nonzero reloads to FLASH_CYCLES.
  - flash_active = (counter != 0).
- Run complete:
  - run_complete sets sticky run_done, cleared only by rst.
- Output priority, highest first, applied to every bit:
  1. run_done: r=0, b=0, g=blink_phase, on all LEDs.
  2. flash_active: r=g=b=1, on all LEDs.
  3. Per-channel colour from the FSM.
- Latency:
  - An input pulse at edge k is visible on the outputs at edge k+1. The FSM updates at edge k; the output register follows one cycle later.
  - run_complete in the same cycle as node_flag: run_done wins from the first visible cycle.
- Channel FSMs keep updating underneath the overlays. The channel colour reappears when the flash ends.

Decomposition:
- Package led_status_pkg holds:
  - the channel state enum: IDLE, ARMED, DETECTED, PICKED, DONE;
  - 3-bit RGB colour constants: OFF, RED, BLUE, GREEN, WHITE;
  - a function mapping state plus blink_phase to RGB.
- Sub-module led_chan_fsm, instantiated N_LEDS times via generate.
- The blink timer, flash counter, run_done and output mux stay in the top.

Test Plan (bench uses N_LEDS=3, BLINK_HALF=8, FLASH_CYCLES=4):
1. Reset sequence: hold rst 3 cycles while driving random events -> led_r/g/b=000 throughout and 1 cycle after release; unit_fault=000 -> outputs stay 0 for 50 cycles.
2. Full channel walk: unit_fault=010; then pulse fault_detect, block_picked, object_drop 5 cycles apart.
   - Expected: led_r=010 (red); then led_b=010 solid; then led_b=010 toggling every 8 cycles; then led_g=010 solid. LEDs 0 and 2 remain 0.
3. Simultaneous events: unit_fault=001, ARMED; pulse fault_detect and object_drop in the same cycle -> led_g=001 next cycle; the blue state is never seen.
4. Frozen state: channel 0 in DETECTED, unit_fault drops to 000, then pulse object_drop -> led_b stays 001.
5. Node flash: channel 2 in ARMED; pulse node_flag, then node_flag again 2 cycles later.
   - Expected: all outputs 111 for 6 cycles total, then led_r=100 restored.
6. Run complete during flash: pulse node_flag then run_complete 1 cycle later.
   - Expected: led_r=led_b=000 and led_g alternating 111/000 per 8-cycle half-period, persisting through subsequent events until rst.

Source files
------------

// File: rtl/led_status_pkg.sv
// Shared types for the RGB status LED controller: channel states, colour
// constants and the state-to-colour mapping used by every channel.
package led_status_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        DETECTED = 3'd2,
        PICKED   = 3'd3,
        DONE     = 3'd4
    } chan_state_e;

    // Colours are packed {r, g, b}.
    localparam logic [2:0] OFF   = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] WHITE = 3'b111;

    function automatic logic [2:0] state_rgb(input chan_state_e st, input logic phase);
        logic [2:0] rgb;
        rgb = OFF;
        case (st)
            ARMED:    rgb = RED;
            DETECTED: rgb = BLUE;
            PICKED:   rgb = phase ? BLUE : OFF;
            DONE:     rgb = GREEN;
            default:  rgb = OFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/led_status_ctrl_chan.sv
// Per-unit fault-progress FSM. Bot events only count while this unit owns
// the fault; dropping ownership freezes the state rather than rewinding it.
module led_chan_fsm
    import led_status_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        unit_fault,
    input  logic        fault_detect,
    input  logic        block_picked,
    input  logic        object_drop,
    output chan_state_e state
);

    chan_state_e state_d;
    chan_state_e state_q;

    // One transition per cycle; object_drop outranks the other events.
    always_comb begin
        state_d = state_q;
        if (unit_fault) begin
            case (state_q)
                IDLE:     state_d = ARMED;
                ARMED:    if (object_drop)       state_d = DONE;
                          else if (fault_detect) state_d = DETECTED;
                DETECTED: if (object_drop)       state_d = DONE;
                          else if (block_picked) state_d = PICKED;
                PICKED:   if (object_drop)       state_d = DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/led_status_ctrl.sv
// N-channel RGB status LED driver: per-unit channel colours with global
// run-complete green blink and retriggerable node white flash overlays.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int N_LEDS       = 3,
    parameter int BLINK_HALF   = 3125000,
    parameter int FLASH_CYCLES = 312500
) (
    input  logic              clk_3125KHz,
    input  logic              rst,
    input  logic [N_LEDS-1:0] unit_fault,
    input  logic              fault_detect,
    input  logic              block_picked,
    input  logic              object_drop,
    input  logic              node_flag,
    input  logic              run_complete,
    output logic [N_LEDS-1:0] led_r,
    output logic [N_LEDS-1:0] led_g,
    output logic [N_LEDS-1:0] led_b
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int FW = $clog2(FLASH_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

    chan_state_e       chan_state [N_LEDS];
    logic [N_LEDS-1:0] chan_r, chan_g, chan_b;

    logic [BW-1:0]     blink_cnt_d, blink_cnt_q;
    logic              blink_phase_d, blink_phase_q;
    logic [FW-1:0]     flash_cnt_d, flash_cnt_q;
    logic              run_done_d, run_done_q;
    logic [N_LEDS-1:0] led_r_d, led_r_q;
    logic [N_LEDS-1:0] led_g_d, led_g_q;
    logic [N_LEDS-1:0] led_b_d, led_b_q;

    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
        logic [2:0] rgb;

        led_chan_fsm u_fsm (
            .clk          (clk_3125KHz),
            .rst          (rst),
            .unit_fault   (unit_fault[i]),
            .fault_detect (fault_detect),
            .block_picked (block_picked),
            .object_drop  (object_drop),
            .state        (chan_state[i])
        );

        assign rgb       = state_rgb(chan_state[i], blink_phase_q);
        assign chan_r[i] = rgb[2];
        assign chan_g[i] = rgb[1];
        assign chan_b[i] = rgb[0];
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        // A retrigger simply reloads, stretching the flash.
        flash_cnt_d = flash_cnt_q;
        if (node_flag)               flash_cnt_d = FLASH_LOAD;
        else if (flash_cnt_q != '0)  flash_cnt_d = flash_cnt_q - FW'(1);

        run_done_d = run_done_q | run_complete;
    end

    // Output mux works from registered state, giving the one-cycle output lag.
    always_comb begin
        led_r_d = chan_r;
        led_g_d = chan_g;
        led_b_d = chan_b;
        if (run_done_q) begin
            led_r_d = '0;
            led_g_d = {N_LEDS{blink_phase_q}};
            led_b_d = '0;
        end else if (flash_cnt_q != '0) begin
            led_r_d = '1;
            led_g_d = '1;
            led_b_d = '1;
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            flash_cnt_q   <= '0;
            run_done_q    <= 1'b0;
            led_r_q       <= '0;
            led_g_q       <= '0;
            led_b_q       <= '0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            flash_cnt_q   <= flash_cnt_d;
            run_done_q    <= run_done_d;
            led_r_q       <= led_r_d;
            led_g_q       <= led_g_d;
            led_b_q       <= led_b_d;
        end
    end

    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign led_b = led_b_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: a behavioural model queues the expected
// {r,g,b} for every edge, plus fixed-colour checks at the key scenario points.
module tb_led_status_ctrl;

    localparam int N  = 3;
    localparam int BH = 8;
    localparam int FC = 4;

    localparam int S_IDLE = 0, S_ARM = 1, S_DET = 2, S_PCK = 3, S_DONE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [N-1:0] unit_fault;
    logic         fault_detect, block_picked, object_drop, node_flag, run_complete;
    logic [N-1:0] led_r, led_g, led_b;

    led_status_ctrl #(.N_LEDS(N), .BLINK_HALF(BH), .FLASH_CYCLES(FC)) dut (
        .clk_3125KHz  (clk),
        .rst          (rst),
        .unit_fault   (unit_fault),
        .fault_detect (fault_detect),
        .block_picked (block_picked),
        .object_drop  (object_drop),
        .node_flag    (node_flag),
        .run_complete (run_complete),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3*N-1:0] exp_q[$];

    int   m_st [N];
    int   m_cnt;
    logic m_ph;
    int   m_fc;
    logic m_rd;

    function automatic logic [3*N-1:0] model_out();
        logic [N-1:0] r, g, b;
        r = '0; g = '0; b = '0;
        if (m_rd) begin
            g = {N{m_ph}};
        end else if (m_fc != 0) begin
            r = '1; g = '1; b = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (m_st[i])
                    S_ARM:   r[i] = 1'b1;
                    S_DET:   b[i] = 1'b1;
                    S_PCK:   b[i] = m_ph;
                    S_DONE:  g[i] = 1'b1;
                    default: ;
                endcase
            end
        end
        return {r, g, b};
    endfunction

    function automatic void model_step();
        if (rst) begin
            for (int i = 0; i < N; i++) m_st[i] = S_IDLE;
            m_cnt = 0; m_ph = 1'b0; m_fc = 0; m_rd = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (unit_fault[i]) begin
                case (m_st[i])
                    S_IDLE: m_st[i] = S_ARM;
                    S_ARM:  if (object_drop) m_st[i] = S_DONE;
                            else if (fault_detect) m_st[i] = S_DET;
                    S_DET:  if (object_drop) m_st[i] = S_DONE;
                            else if (block_picked) m_st[i] = S_PCK;
                    S_PCK:  if (object_drop) m_st[i] = S_DONE;
                    default: ;
                endcase
            end
        end
        if (m_cnt == BH - 1) begin m_cnt = 0; m_ph = ~m_ph; end
        else m_cnt++;
        if (node_flag) m_fc = FC;
        else if (m_fc != 0) m_fc--;
        if (run_complete) m_rd = 1'b1;
    endfunction

    // One clock: queue the expectation for this edge, advance the model,
    // then compare the DUT just after the edge and clear the pulses.
    task automatic tick();
        logic [3*N-1:0] e, got;
        e = rst ? '0 : model_out();
        exp_q.push_back(e);
        model_step();
        @(posedge clk); #1;
        got = {led_r, led_g, led_b};
        e = exp_q.pop_front();
        n_cmp++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL model_out: got r=%b g=%b b=%b exp r=%b g=%b b=%b",
                   got[3*N-1:2*N], got[2*N-1:N], got[N-1:0],
                   e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
        end
        fault_detect = 1'b0; block_picked = 1'b0; object_drop = 1'b0;
        node_flag = 1'b0; run_complete = 1'b0;
    endtask

    task automatic expect_rgb(input string tag, input logic [N-1:0] r,
                              input logic [N-1:0] g, input logic [N-1:0] b);
        n_cmp++;
        assert ({led_r, led_g, led_b} === {r, g, b}) else begin
            n_err++;
            $error("FAIL %s: got r=%b g=%b b=%b exp r=%b g=%b b=%b",
                   tag, led_r, led_g, led_b, r, g, b);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int e);
        n_cmp++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s: got %0d exp %0d", tag, got, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tick();
        rst = 1'b0;
    endtask

    initial begin
        int on;
        rst = 1'b1; unit_fault = '0;
        fault_detect = 1'b0; block_picked = 1'b0; object_drop = 1'b0;
        node_flag = 1'b0; run_complete = 1'b0;
        for (int i = 0; i < N; i++) m_st[i] = S_IDLE;
        m_cnt = 0; m_ph = 1'b0; m_fc = 0; m_rd = 1'b0;

        // 1: reset held with random activity, then idle with no owner
        repeat (3) begin
            unit_fault   = N'($urandom_range(7, 0));
            fault_detect = 1'($urandom_range(1, 0));
            block_picked = 1'($urandom_range(1, 0));
            object_drop  = 1'($urandom_range(1, 0));
            node_flag    = 1'($urandom_range(1, 0));
            run_complete = 1'($urandom_range(1, 0));
            tick();
            expect_rgb("rst_hold", '0, '0, '0);
        end
        rst = 1'b0; unit_fault = '0;
        tick();
        expect_rgb("rst_release", '0, '0, '0);
        repeat (50) begin
            fault_detect = 1'($urandom_range(1, 0));
            object_drop  = 1'($urandom_range(1, 0));
            tick();
        end
        expect_rgb("idle_50", '0, '0, '0);

        // 2: full walk on channel 1
        unit_fault = 3'b010;
        tick(); tick();
        expect_rgb("walk_armed", 3'b010, '0, '0);
        fault_detect = 1'b1; tick(); tick();
        expect_rgb("walk_detected", '0, '0, 3'b010);
        repeat (3) tick();
        block_picked = 1'b1; tick();
        repeat (4) tick();
        on = 0;
        repeat (16) begin
            tick();
            if (led_b == 3'b010) on++;
        end
        expect_int("walk_blink_on", on, 8);
        object_drop = 1'b1; tick(); tick();
        expect_rgb("walk_done", '0, 3'b010, '0);
        repeat (5) tick();

        // 3: simultaneous detect + drop from ARMED goes straight to DONE
        do_reset();
        unit_fault = 3'b001;
        tick();
        fault_detect = 1'b1; object_drop = 1'b1; tick();
        expect_rgb("simul_armed", 3'b001, '0, '0);
        tick();
        expect_rgb("simul_done", '0, 3'b001, '0);

        // 4: dropping ownership freezes DETECTED
        do_reset();
        unit_fault = 3'b001;
        tick();
        fault_detect = 1'b1; tick();
        unit_fault = '0;
        object_drop = 1'b1; tick(); tick();
        expect_rgb("frozen_a", '0, '0, 3'b001);
        block_picked = 1'b1; tick(); tick(); tick();
        expect_rgb("frozen_b", '0, '0, 3'b001);

        // 5: retriggered node flash over channel 2 ARMED
        do_reset();
        unit_fault = 3'b100;
        tick(); tick();
        expect_rgb("flash_pre", 3'b100, '0, '0);
        node_flag = 1'b1; tick();
        tick();
        expect_rgb("flash_1", '1, '1, '1);
        node_flag = 1'b1; tick();
        expect_rgb("flash_2", '1, '1, '1);
        repeat (4) begin
            tick();
            expect_rgb("flash_n", '1, '1, '1);
        end
        tick();
        expect_rgb("flash_end", 3'b100, '0, '0);

        // 6: run complete during flash; green blink overrides everything
        node_flag = 1'b1; tick();
        run_complete = 1'b1; tick();
        expect_rgb("run_flash", '1, '1, '1);
        on = 0;
        repeat (16) begin
            fault_detect = 1'($urandom_range(1, 0));
            object_drop  = 1'($urandom_range(1, 0));
            node_flag    = 1'($urandom_range(1, 0));
            unit_fault   = N'($urandom_range(7, 0));
            tick();
            if (led_r == '0 && led_b == '0 && led_g == '1) on++;
        end
        expect_int("run_blink_on", on, 8);
        do_reset();
        expect_rgb("run_cleared", '0, '0, '0);

        // run_complete and node_flag together: run_done wins at once
        unit_fault = '0;
        node_flag = 1'b1; run_complete = 1'b1; tick(); tick();
        expect_int("run_wins_rb", int'({led_r, led_b}), 0);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
